msx_rom_fetch: RTL
==================

MSX_ROM_FETCH -- requirements
Module: msx_rom_fetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles from fetch start to data before abort (range 2..1023).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port ram_cs, input, 1: mapper RAM chip select, held high for the whole CPU read.
REQ-005 The block SHALL have port ram_addr, input, 27: mapper RAM byte address, valid while ram_cs=1.
REQ-006 The block SHALL have port invalidate, input, 1: one-cycle pulse issued on any bank-register write.
REQ-007 The block SHALL have port cpu_wait, output, 1: high while the CPU read must be stretched.
REQ-008 The block SHALL have port cpu_data, output, 8: read byte for the CPU.
REQ-009 The block SHALL have port mem_req, output, 1: memory read request, registered.
REQ-010 The block SHALL have port mem_addr, output, 27: memory address, registered.
REQ-011 The block SHALL have port mem_ack, input, 1: memory accepted the request.
REQ-012 The block SHALL have port mem_rvalid, input, 1: mem_rdata is valid this cycle.
REQ-013 The block SHALL have port mem_rdata, input, 8: memory read data.
REQ-014 The block SHALL have port timeout_err, output, 1: sticky fetch-abort flag.

Function
REQ-015 The block SHALL hold a one-entry cache: last_addr (27b), last_data (8b), last_valid (1b).
REQ-016 hit SHALL be combinational: last_valid && last_addr==ram_addr.
REQ-017 cpu_wait SHALL be combinational: ram_cs && !hit, so a hit gives zero wait states.
REQ-018 cpu_data SHALL equal last_data at all times.
REQ-019 The FSM SHALL have states IDLE, REQ and WAIT.
REQ-020 IDLE: on ram_cs && !hit, the block SHALL latch mem_addr<=ram_addr, set mem_req<=1 and go to REQ.
REQ-021 REQ: mem_req SHALL stay high and mem_addr stable until mem_ack is sampled high. The block SHALL then drop mem_req the following cycle and go to WAIT.
REQ-022 If mem_ack and mem_rvalid are high in the same cycle in REQ, the block SHALL complete the fetch exactly as in REQ-023.
REQ-023 WAIT: on mem_rvalid the block SHALL set last_data<=mem_rdata, last_addr<=mem_addr and last_valid<=1, then go to IDLE.
REQ-024 mem_rvalid SHALL be ignored in IDLE, and in REQ before mem_ack.
REQ-025 A 10-bit counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-026 When the counter reaches TIMEOUT_CYCLES-1 without completion, the block SHALL set last_data<=8'hFF, last_addr<=mem_addr, last_valid<=1, timeout_err<=1 and mem_req<=0, then go to IDLE.
REQ-027 A fetch in progress SHALL complete even if ram_cs or ram_addr changes. The result is cached, and a new miss starts only from IDLE.
REQ-028 invalidate SHALL clear last_valid next cycle and SHALL take priority over a simultaneous fill from REQ-023 or REQ-026. The in-flight fetch continues but its data is not marked valid.
REQ-029 After completion, a CPU read still pending at the same address SHALL see hit=1 and cpu_wait=0 in the next cycle.
REQ-030 timeout_err SHALL clear only on reset.

Reset
REQ-031 While reset_n=0 the block SHALL force: state IDLE, mem_req=0, mem_addr=0, last_valid=0, last_addr=0, last_data=8'hFF, counter=0, timeout_err=0.
REQ-032 Reset asserted mid-fetch SHALL abort the fetch immediately, with mem_req low asynchronously.
REQ-033 cpu_wait SHALL equal ram_cs during reset.

Verification
REQ-034 Miss: ram_cs=1, addr=0x02000; mem_ack 2 cycles later; mem_rvalid with 0x5A 3 cycles after that -> cpu_wait high throughout, mem_req high exactly until ack+1, cpu_data=0x5A, and cpu_wait low the cycle after rvalid.
REQ-035 Hit: repeat the read at 0x02000 -> cpu_wait stays 0, mem_req never rises, cpu_data=0x5A.
REQ-036 Same-cycle handshake: mem_ack and mem_rvalid together with 0x33 -> fill completes; state IDLE next cycle.
REQ-037 Timeout: TIMEOUT_CYCLES=8, memory never acks -> mem_req drops after 8 cycles, cpu_data=0xFF, timeout_err=1 until reset_n pulse.
REQ-038 invalidate coincident with mem_rvalid -> last_valid=0, and the same address re-read issues a new mem_req.
REQ-039 reset_n low during WAIT -> mem_req=0 and last_valid=0 immediately, and the FSM restarts cleanly on the next miss.

Source files
------------

// File: rtl/msx_rom_fetch.sv
// msx_rom_fetch: one-entry read cache in front of a request/ack/rvalid memory
// port. A CPU read that hits the cached byte completes with no wait states;
// a miss stretches the CPU with cpu_wait while the byte is fetched. A fetch
// that does not finish within TIMEOUT_CYCLES is aborted and returns 8'hFF.
module msx_rom_fetch #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ram_cs,
   input  logic [26:0] ram_addr,
   input  logic        invalidate,
   output logic        cpu_wait,
   output logic [7:0]  cpu_data,
   output logic        mem_req,
   output logic [26:0] mem_addr,
   input  logic        mem_ack,
   input  logic        mem_rvalid,
   input  logic [7:0]  mem_rdata,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Last count value before the abort fires; the counter is 0 on the first
   // REQ cycle, so reaching this value means TIMEOUT_CYCLES cycles elapsed.
   localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [26:0] last_addr, last_addr_nxt;
   logic [7:0]  last_data, last_data_nxt;
   logic        last_valid, last_valid_nxt;
   logic        mem_req_nxt;
   logic [26:0] mem_addr_nxt;
   logic [9:0]  cnt, cnt_nxt;
   logic        timeout_nxt;
   logic        hit;
   logic        fill;
   logic        abort;

   assign hit      = last_valid && (last_addr == ram_addr);
   assign cpu_wait = ram_cs && !hit;
   assign cpu_data = last_data;

   // Next-state and next-value logic for the fetch FSM and the cache entry.
   always_comb begin
      state_nxt      = state;
      mem_req_nxt    = mem_req;
      mem_addr_nxt   = mem_addr;
      cnt_nxt        = cnt;
      last_addr_nxt  = last_addr;
      last_data_nxt  = last_data;
      last_valid_nxt = last_valid;
      timeout_nxt    = timeout_err;
      fill           = 1'b0;
      abort          = 1'b0;

      case (state)
         IDLE: begin
            if (ram_cs && !hit) begin
               mem_addr_nxt = ram_addr;
               mem_req_nxt  = 1'b1;
               cnt_nxt      = 10'd0;
               state_nxt    = REQ;
            end
         end
         REQ: begin
            cnt_nxt = cnt + 10'd1;
            // rvalid only counts once the request has been accepted
            if (mem_ack) begin
               mem_req_nxt = 1'b0;
               if (mem_rvalid) begin
                  fill = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
            if (!fill && (cnt == CNT_LAST)) begin
               abort = 1'b1;
            end
         end
         WAIT: begin
            cnt_nxt = cnt + 10'd1;
            if (mem_rvalid) begin
               fill = 1'b1;
            end else if (cnt == CNT_LAST) begin
               abort = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Completion wins over a timeout landing in the same cycle.
      if (fill) begin
         last_data_nxt  = mem_rdata;
         last_addr_nxt  = mem_addr;
         last_valid_nxt = 1'b1;
         mem_req_nxt    = 1'b0;
         state_nxt      = IDLE;
      end else if (abort) begin
         last_data_nxt  = 8'hFF;
         last_addr_nxt  = mem_addr;
         last_valid_nxt = 1'b1;
         timeout_nxt    = 1'b1;
         mem_req_nxt    = 1'b0;
         state_nxt      = IDLE;
      end

      // A bank switch makes the cached byte stale, even one arriving now.
      if (invalidate) begin
         last_valid_nxt = 1'b0;
      end
   end

   // State and datapath registers; reset aborts any fetch immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         mem_req     <= 1'b0;
         mem_addr    <= 27'd0;
         cnt         <= 10'd0;
         last_addr   <= 27'd0;
         last_data   <= 8'hFF;
         last_valid  <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         mem_req     <= mem_req_nxt;
         mem_addr    <= mem_addr_nxt;
         cnt         <= cnt_nxt;
         last_addr   <= last_addr_nxt;
         last_data   <= last_data_nxt;
         last_valid  <= last_valid_nxt;
         timeout_err <= timeout_nxt;
      end
   end

endmodule
